// File: rtl/nes_oam_dma.sv
// nes_oam_dma: CPU bus arbiter and OAM DMA engine for the NES.
// A CPU write to DMA_REG_ADDR halts the CPU and copies one 256-byte page to OAM_DATA_ADDR.
module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_R_WN,
    input  logic [7:0]  CPU_ODATA,
    output logic [7:0]  CPU_IDATA,
    output logic        CPU_RDY,
    output logic [15:0] BUS_ADDR,
    output logic        BUS_R_WN,
    output logic [7:0]  BUS_ODATA,
    input  logic [7:0]  BUS_IDATA,
    output logic        DMA_ACTIVE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] buf_q, buf_d;
    logic       par_q, par_d;
    logic       trigger_s;

    assign trigger_s = (CPU_ADDR == DMA_REG_ADDR) && (CPU_R_WN == 1'b0);

    // Next-state and datapath update; par is free-running so every READ lands on par==0.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        par_d   = ~par_q;
        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    page_d  = CPU_ODATA;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (par_q) begin
                    state_d = READ;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                buf_d   = BUS_IDATA;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            buf_q   <= 8'h00;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            par_q   <= par_d;
        end
    end

    // Bus ownership mux: CPU passthrough in IDLE, DMA drive otherwise.
    always_comb begin
        BUS_ADDR  = CPU_ADDR;
        BUS_R_WN  = 1'b1;
        BUS_ODATA = buf_q;
        case (state_q)
            IDLE: begin
                BUS_ADDR  = CPU_ADDR;
                BUS_R_WN  = CPU_R_WN;
                BUS_ODATA = CPU_ODATA;
            end
            HALT, ALIGN: begin
                BUS_ADDR = CPU_ADDR;
                BUS_R_WN = 1'b1;
            end
            READ: begin
                BUS_ADDR = {page_q, idx_q};
                BUS_R_WN = 1'b1;
            end
            WRITE: begin
                BUS_ADDR = OAM_DATA_ADDR;
                BUS_R_WN = 1'b0;
            end
            default: begin
                BUS_ADDR = CPU_ADDR;
                BUS_R_WN = 1'b1;
            end
        endcase
    end

    assign CPU_RDY    = (state_q == IDLE);
    assign DMA_ACTIVE = ~CPU_RDY;
    assign CPU_IDATA  = BUS_IDATA;

endmodule

// File: doc/nes_oam_dma.md
# nes_oam_dma

OAM DMA controller and CPU-bus arbiter for the NES console. It sits between the 6502 core's bus master port and the system bus (RAM/PPU decode). A CPU write to $4014 halts the CPU. The block then takes ownership of the bus and copies 256 bytes from page $XX00–$XXFF to the PPU OAMDATA register at $2004, then returns the bus to the CPU.

## Interface
Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- CLK  input  1  system clock; one CLK = one CPU bus cycle.
- RST_N  input  1  asynchronous, active-low reset.
- CPU_ADDR  input  16  CPU master address.
- CPU_R_WN  input  1  CPU read(1)/write(0).
- CPU_ODATA  input  8  CPU write data.
- CPU_IDATA  output  8  read data returned to the CPU; always equal to BUS_IDATA.
- CPU_RDY  output  1  when 0, the CPU holds its state and its bus outputs.
- BUS_ADDR  output  16  system bus address.
- BUS_R_WN  output  1  system bus read/write.
- BUS_ODATA  output  8  system bus write data.
- BUS_IDATA  input  8  system bus read data.
- DMA_ACTIVE  output  1  high whenever the DMA state machine is not IDLE.

## Operation
- State machine states: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - page[7:0]: source high byte.
  - idx[7:0]: byte index.
  - buf[7:0]: fetched byte.
  - par: cycle parity. par toggles every CLK; reset value 0; free-running and never gated.
- Bus ownership: in IDLE the BUS_* outputs are CPU_* passed through combinationally. In any other state the DMA drives the bus.
- IDLE:
  - Trigger condition: CPU_ADDR==DMA_REG_ADDR and CPU_R_WN==0.
  - On trigger: page<=CPU_ODATA, idx<=0, next state HALT.
  - The trigger write itself still passes through to the bus.
  - All other CPU accesses have no effect on the block.
- HALT:
  - One dummy cycle. Bus: BUS_ADDR=CPU_ADDR, BUS_R_WN=1 (dummy read, no write).
  - Next state: READ if par==1, ALIGN if par==0. This guarantees every READ cycle has par==0.
- ALIGN: one dummy cycle, same bus drive as HALT; next state READ.
- READ: BUS_ADDR={page,idx}, BUS_R_WN=1. buf<=BUS_IDATA at the closing edge; next state WRITE.
- WRITE: BUS_ADDR=OAM_DATA_ADDR, BUS_R_WN=0, BUS_ODATA=buf.
  - If idx==8'hFF: next state IDLE.
  - Otherwise: idx<=idx+1, next state READ.
- Address arithmetic: idx is 8-bit and never carries into page. Page $FF reads $FF00–$FFFF.
- CPU_RDY = (state==IDLE), combinational from the registered state.
- DMA_ACTIVE = !CPU_RDY.
- BUS_ODATA: outside WRITE in DMA states it is don't-care; drive it as buf.

## Timing
- Reset (RST_N=0, asynchronous):
  - state=IDLE, page=0, idx=0, buf=0, par=0.
  - CPU_RDY=1, DMA_ACTIVE=0.
  - BUS_* follow CPU_* combinationally. CPU_IDATA=BUS_IDATA.
- Trigger write in cycle T. CPU_RDY falls in cycle T+1 (HALT).
- Total halt length, counting from T+1 to the last WRITE inclusive:
  - 513 cycles if par==1 in T+1.
  - 514 cycles if par==0 in T+1.
- The first READ occurs in T+2 (no ALIGN) or T+3 (with ALIGN).
- READ and WRITE strictly alternate: 256 pairs, byte n is written exactly one cycle after it is read.
- CPU_RDY rises in the cycle after the final WRITE (state IDLE); the CPU resumes that cycle.
- A new $4014 write is accepted in the first IDLE cycle after completion. No back-to-back lockout.
- Reset asserted mid-DMA:
  - Immediately IDLE, CPU_RDY=1, bus returned to the CPU.
  - The partial transfer is abandoned; no further $2004 writes occur.
- CPU_ADDR/CPU_R_WN changes while CPU_RDY=0 are ignored. Triggers are only decoded in IDLE.

## Test plan
- Page $02 DMA, RAM $0200+n = n^8'hA5: expect 256 writes to $2004 in order, carrying A5, A4, …, 5A. Expect CPU_RDY=0 for 513 or 514 cycles, matching par in HALT.
- Parity alignment: trigger once with par==1 in HALT and once with par==0. Expect ALIGN absent/present, halt length 513/514, and par==0 in every READ cycle.
- Page $FF: expect source reads $FF00..$FFFF only. No read of $0000 (no carry into page).
- Non-trigger accesses: a read of $4014, a write to $4015, and a write to $2004. Expect no state change, CPU_RDY held at 1, pure bus passthrough.
- Reset mid-transfer: assert RST_N=0 after the 100th WRITE. Expect CPU_RDY=1 and DMA_ACTIVE=0 immediately (asynchronous), then no further $2004 writes.
- Back-to-back: the CPU writes $4014=$03 on its first cycle after a completed DMA. Expect a second full 256-byte transfer from $0300.
